// File: rtl/prbs_test_ctrl_if.sv
// Command/status bundle between the register bank, the PRBS sequencer and
// the generator/checker strobes.
//   master: drives start/abort, test_len/inj_beat, gen_beat, chk_beat/chk_err
//   slave : drives cfg_gen_en/cfg_chk_en/cfg_gen_err, busy, done, pass,
//           sync_fail, beat_cnt, err_cnt, state
interface prbs_test_ctrl_if #(
  parameter int unsigned REG_DW = 32
) ();
  logic              start;
  logic              abort;
  logic [REG_DW-1:0] test_len;
  logic [REG_DW-1:0] inj_beat;
  logic              gen_beat;
  logic              chk_beat;
  logic              chk_err;
  logic              cfg_gen_en;
  logic              cfg_chk_en;
  logic              cfg_gen_err;
  logic              busy;
  logic              done;
  logic              pass;
  logic              sync_fail;
  logic [REG_DW-1:0] beat_cnt;
  logic [REG_DW-1:0] err_cnt;
  logic [1:0]        state;

  modport master (
    output start, abort, test_len, inj_beat, gen_beat, chk_beat, chk_err,
    input  cfg_gen_en, cfg_chk_en, cfg_gen_err, busy, done, pass, sync_fail,
           beat_cnt, err_cnt, state
  );

  modport slave (
    input  start, abort, test_len, inj_beat, gen_beat, chk_beat, chk_err,
    output cfg_gen_en, cfg_chk_en, cfg_gen_err, busy, done, pass, sync_fail,
           beat_cnt, err_cnt, state
  );
endinterface

// File: rtl/prbs_test_ctrl.sv
// PRBS test sequencer: on start enables generator and checker, waits for
// SYNC_LEN consecutive clean checker beats (or SYNC_TIMEOUT cycles), runs a
// measurement of test_len checker beats, optionally corrupts one generator
// beat, and reports pass/fail.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of prbs_test_ctrl_if (commands, beat strobes,
//                reg_cfg enables, status and counters)
module prbs_test_ctrl #(
  parameter int unsigned REG_DW       = 32,
  parameter int unsigned SYNC_LEN     = 16,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  prbs_test_ctrl_if.slave bus
);
  localparam int unsigned SR_W  = $clog2(SYNC_LEN + 1);
  localparam int unsigned TMO_W = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [REG_DW-1:0] test_len_q, test_len_d;
  logic [REG_DW-1:0] inj_beat_q, inj_beat_d;
  logic [REG_DW-1:0] beat_cnt_q, beat_cnt_d;
  logic [REG_DW-1:0] err_cnt_q, err_cnt_d;
  logic [REG_DW-1:0] gen_run_q, gen_run_d;
  logic [SR_W-1:0]   sync_run_q, sync_run_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              inj_done_q, inj_done_d;
  logic              pass_q, pass_d;
  logic              sync_fail_q, sync_fail_d;
  logic              done_q, done_d;
  logic              gen_en_q, gen_en_d;
  logic              chk_en_q, chk_en_d;
  logic              busy_q, busy_d;
  logic              beat_v;
  logic              gen_err_c;

  // Checker beats only count while the checker is enabled.
  assign beat_v = bus.chk_beat & chk_en_q;

  // Marks the generator beat that must carry the injected error.
  assign gen_err_c = (state_q == S_RUN) && (inj_beat_q != '0) && !inj_done_q &&
                     (gen_run_q == (inj_beat_q - REG_DW'(1)));

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      test_len_q  <= '0;
      inj_beat_q  <= '0;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      gen_run_q   <= '0;
      sync_run_q  <= '0;
      tmo_q       <= '0;
      inj_done_q  <= 1'b0;
      pass_q      <= 1'b0;
      sync_fail_q <= 1'b0;
      done_q      <= 1'b0;
      gen_en_q    <= 1'b0;
      chk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      test_len_q  <= test_len_d;
      inj_beat_q  <= inj_beat_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      gen_run_q   <= gen_run_d;
      sync_run_q  <= sync_run_d;
      tmo_q       <= tmo_d;
      inj_done_q  <= inj_done_d;
      pass_q      <= pass_d;
      sync_fail_q <= sync_fail_d;
      done_q      <= done_d;
      gen_en_q    <= gen_en_d;
      chk_en_q    <= chk_en_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, counter and result decode.
  always_comb begin
    state_d     = state_q;
    test_len_d  = test_len_q;
    inj_beat_d  = inj_beat_q;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    gen_run_d   = gen_run_q;
    sync_run_d  = sync_run_q;
    tmo_d       = tmo_q;
    inj_done_d  = inj_done_q;
    pass_d      = pass_q;
    sync_fail_d = sync_fail_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = S_SYNC;
          test_len_d  = bus.test_len;
          inj_beat_d  = bus.inj_beat;
          beat_cnt_d  = '0;
          err_cnt_d   = '0;
          gen_run_d   = '0;
          sync_run_d  = '0;
          tmo_d       = '0;
          inj_done_d  = 1'b0;
          pass_d      = 1'b0;
          sync_fail_d = 1'b0;
        end
      end

      S_SYNC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (beat_v) begin
            sync_run_d = bus.chk_err ? '0 : sync_run_q + SR_W'(1);
          end
          // Lock wins over a timeout landing in the same cycle.
          if (beat_v && !bus.chk_err && (sync_run_q == SR_W'(SYNC_LEN - 1))) begin
            state_d = S_RUN;
          end else if (tmo_q == TMO_W'(SYNC_TIMEOUT - 1)) begin
            state_d     = S_DONE;
            sync_fail_d = 1'b1;
            pass_d      = 1'b0;
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          if (bus.gen_beat) begin
            gen_run_d = gen_run_q + REG_DW'(1);
            if (gen_err_c) inj_done_d = 1'b1;
          end
          if (beat_v) begin
            beat_cnt_d = beat_cnt_q + REG_DW'(1);
            if (bus.chk_err && (err_cnt_q != {REG_DW{1'b1}})) begin
              err_cnt_d = err_cnt_q + REG_DW'(1);
            end
            if ((test_len_q != '0) && (beat_cnt_d == test_len_q)) begin
              state_d = S_DONE;
              pass_d  = (inj_beat_q == '0) ? (err_cnt_d == '0) : (err_cnt_d != '0);
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (bus.abort) pass_d = 1'b0;
      end
    endcase

    gen_en_d = (state_d == S_SYNC) || (state_d == S_RUN);
    chk_en_d = gen_en_d;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  assign bus.cfg_gen_en  = gen_en_q;
  assign bus.cfg_chk_en  = chk_en_q;
  assign bus.cfg_gen_err = gen_err_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.sync_fail   = sync_fail_q;
  assign bus.beat_cnt    = beat_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.state       = state_q;
endmodule
